// File: rtl/game_timer_if.sv
// Game-control inputs plus timer status, BCD digits and 7-segment outputs.
// Purely wiring: no storage, no latency of its own.
// No backpressure; every signal is a level or a single-cycle pulse.
interface game_timer_if;
    logic       start;
    logic       win;
    logic       lose;
    logic       running;
    logic       sec_tick;
    logic       time_up;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_hund;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic [6:0] HEX6;

    // Game control side: drives start/win/lose, observes the timer.
    modport master (
        output start, win, lose,
        input  running, sec_tick, time_up,
        input  bcd_ones, bcd_tens, bcd_hund,
        input  HEX4, HEX5, HEX6
    );

    // Timer side.
    modport slave (
        input  start, win, lose,
        output running, sec_tick, time_up,
        output bcd_ones, bcd_tens, bcd_hund,
        output HEX4, HEX5, HEX6
    );
endinterface

// File: rtl/game_timer.sv
// Counts whole seconds of play in 3-digit BCD, flags a time limit, drives HEX4..HEX6.
// running follows a start edge by 1 cycle; first sec_tick/count TICKS_PER_SEC cycles after that.
// No backpressure; win/lose freeze the count on the next edge and beat a coincident tick.
module game_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TIME_LIMIT    = 300
) (
    input logic         Clk,
    input logic         Reset,
    game_timer_if.slave tif
);

    localparam int              PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PS_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0]   PS_ONE   = PW'(1);
    localparam logic [9:0]      LIMIT    = 10'(TIME_LIMIT);
    localparam logic [9:0]      SAT      = 10'd999;
    localparam bit              LIMIT_EN = (TIME_LIMIT != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] prescaler;
    logic [3:0]    ones, tens, hund;
    logic [9:0]    sec_bin;
    logic          start_q;
    logic          sec_tick_r;
    logic          time_up_r;

    logic [3:0]    nxt_ones, nxt_tens, nxt_hund;
    logic [9:0]    nxt_bin;
    logic          start_edge;
    logic          stop_req;
    logic          tick_due;
    logic          hit_limit;

    assign start_edge = tif.start & ~start_q;
    assign stop_req   = tif.win | tif.lose;
    assign tick_due   = (prescaler == PS_MAX);

    // Next count value: BCD ripple increment with binary shadow, both saturating at 999.
    always_comb begin
        nxt_ones = ones;
        nxt_tens = tens;
        nxt_hund = hund;
        nxt_bin  = sec_bin;
        if (sec_bin != SAT) begin
            nxt_bin = sec_bin + 10'd1;
            if (ones == 4'd9) begin
                nxt_ones = 4'd0;
                if (tens == 4'd9) begin
                    nxt_tens = 4'd0;
                    nxt_hund = hund + 4'd1;
                end else begin
                    nxt_tens = tens + 4'd1;
                end
            end else begin
                nxt_ones = ones + 4'd1;
            end
        end
    end

    // The limit is only reached by a real increment, never by sitting at saturation.
    assign hit_limit = LIMIT_EN && (sec_bin != SAT) && (nxt_bin == LIMIT);

    // Control FSM, prescaler and count registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            prescaler  <= '0;
            ones       <= 4'd0;
            tens       <= 4'd0;
            hund       <= 4'd0;
            sec_bin    <= 10'd0;
            start_q    <= 1'b0;
            sec_tick_r <= 1'b0;
            time_up_r  <= 1'b0;
        end else begin
            start_q    <= tif.start;
            sec_tick_r <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // Prescaler parks at 0 outside RUN; a fresh start edge clears everything.
                    prescaler <= '0;
                    if (start_edge) begin
                        state     <= S_RUN;
                        ones      <= 4'd0;
                        tens      <= 4'd0;
                        hund      <= 4'd0;
                        sec_bin   <= 10'd0;
                        time_up_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    // win/lose wins over a coincident tick so the frozen count is the visible one.
                    if (stop_req) begin
                        state     <= S_DONE;
                        prescaler <= '0;
                    end else if (tick_due) begin
                        prescaler  <= '0;
                        sec_tick_r <= 1'b1;
                        ones       <= nxt_ones;
                        tens       <= nxt_tens;
                        hund       <= nxt_hund;
                        sec_bin    <= nxt_bin;
                        if (hit_limit) begin
                            time_up_r <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else begin
                        prescaler <= prescaler + PS_ONE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    prescaler <= '0;
                end
            endcase
        end
    end

    // Active-low segments, bit 0 = a; unreachable codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tif.running  = (state == S_RUN);
    assign tif.sec_tick = sec_tick_r;
    assign tif.time_up  = time_up_r;
    assign tif.bcd_ones = ones;
    assign tif.bcd_tens = tens;
    assign tif.bcd_hund = hund;
    assign tif.HEX4     = seg7(ones);
    assign tif.HEX5     = seg7(tens);
    assign tif.HEX6     = seg7(hund);

endmodule

// File: doc/game_timer.md
# game_timer

Elapsed-time stage for the maze/hangman game. It consumes the game-control `start`, `win` and `lose` signals and counts whole seconds of play in three-digit BCD. It raises `time_up` when a configurable limit is reached, which the team wires to `lose`. It drives three active-low 7-segment digits, replacing the ad-hoc seconds counter chain on HEX4–HEX6.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 50000000: `Clk` cycles per second. Must be ≥2.
- `TIME_LIMIT`, default 300: seconds until `time_up`. 0 disables the limit. Valid range 0..999.

Ports:
- `Clk`, input, 1: the single clock.
- `Reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level from game control. Only its 0→1 edge is acted on.
- `win`, input, 1: level. Freezes the timer.
- `lose`, input, 1: level. Freezes the timer.
- `running`, output, 1: high while in state RUN.
- `sec_tick`, output, 1: one-cycle pulse on each counted second.
- `time_up`, output, 1: level. Count reached `TIME_LIMIT`.
- `bcd_ones`, output, 4: seconds, ones digit.
- `bcd_tens`, output, 4: seconds, tens digit.
- `bcd_hund`, output, 4: seconds, hundreds digit.
- `HEX4`, output, 7: segments for the ones digit, active-low, bit 0 = segment a.
- `HEX5`, output, 7: segments for the tens digit, same encoding.
- `HEX6`, output, 7: segments for the hundreds digit, same encoding.

## Operation

- States are IDLE, RUN and DONE.
- State, prescaler, all BCD digits, the binary seconds counter, `start_q`, `sec_tick` and `time_up` are registers, cleared by `Reset`=0.
- Reset state is IDLE. Reset values: `running`=0, `sec_tick`=0, `time_up`=0, all digits 0, so every HEX output reads 7'b1000000 ("0").
- Start edge: `start_edge = start & ~start_q`. `start_q` is a register that follows `start` every cycle.
- IDLE:
  - `start_edge` → RUN. On that edge, clear the prescaler, digits, binary count and `time_up`.
  - `win`/`lose` have no effect.
- RUN:
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0.
  - At the cycle where the prescaler equals TICKS_PER_SEC-1, the next edge asserts `sec_tick` for one cycle and increments the count.
  - BCD increment: ones 9→0 carries to tens, tens 9→0 carries to hundreds.
  - Saturation: at 999 the count holds and `sec_tick` still pulses.
  - The binary seconds counter (10 bits) increments in lockstep and saturates at 999.
- Time limit: when `TIME_LIMIT`≠0 and the incremented value equals `TIME_LIMIT`, on the same edge:
  - `time_up`←1;
  - state → DONE;
  - the digits show `TIME_LIMIT`.
- `win` or `lose` high in RUN → DONE on the next edge. The count is frozen at its current value.
- Priority: `win`/`lose` beats a coincident tick. The increment and `sec_tick` are suppressed that cycle.
- DONE:
  - Digits and `time_up` hold.
  - The prescaler holds at 0.
  - `start_edge` → RUN with the same clears as from IDLE.
- In RUN, `start_edge` is ignored, so holding `start` high never restarts the timer.
- Segment decode is combinational from the registered digits. Digits 0–9 use the standard patterns; codes 10–15 cannot occur and drive 7'b1111111 (blank).

## Timing

- `start` rises before edge k: `running`=1 after edge k.
- The first `sec_tick` and `bcd_ones`=1 become visible after edge k+TICKS_PER_SEC.
- `sec_tick` and the digit update change on the same edge. `sec_tick` lasts exactly one cycle.
- `win`/`lose` sampled high at edge j: `running`=0 after edge j. The count is never changed at edge j.
- `time_up` rises on the same edge as the limiting increment. It stays high until the next `start_edge` or `Reset`.
- `Reset` asserted mid-RUN forces all outputs to their reset values immediately (asynchronous). Release takes effect at the next edge, with state IDLE.
- Prescaler width is $clog2(TICKS_PER_SEC). No arithmetic overflow is possible, given saturation at 999.

## Test plan

All scenarios use `TICKS_PER_SEC`=10.

1. Basic count and carry (`TIME_LIMIT`=0): pulse `start`, run 110 cycles → 11 `sec_tick` pulses, each spaced 10 cycles apart; digits read 0/1/1; HEX4=7'b1111001, HEX5=7'b1111001.
2. Saturation (`TIME_LIMIT`=0): run 10,050 cycles → digits 9/9/9 from second 999 onward with no wrap; `sec_tick` keeps pulsing.
3. Win at a tick: assert `win` in the cycle where the prescaler is 9 with count 004 → count stays 004, no `sec_tick`, `running`=0 next cycle. Repeat the same check with `lose`.
4. Time limit (`TIME_LIMIT`=5): start → after 50 cycles, `time_up`=1, state DONE, digits 005; 30 more cycles leave them unchanged.
5. Restart rules: in DONE, hold `start` high → no restart. Drop `start` then raise it → digits 000, `time_up`=0, `running`=1. Holding `start` high through RUN never clears the count.
6. Reset mid-run at count 007: drive `Reset`=0 between edges → all digits 0, `running`/`sec_tick`/`time_up`=0, and HEX4..6=7'b1000000 before the next edge. After release the timer stays IDLE until a `start` edge.
